// File: rtl/pid_chn_scheduler_if.sv
// Channel-multiplexed request port into the PID core: one registered request
// (channel, feedback, reference) qualified by valid, accepted on ready.
interface pid_chn_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHN_WIDTH  = 3
);
  logic                  data_valid_o;
  logic [CHN_WIDTH-1:0]  data_chn_o;
  logic [DATA_WIDTH-1:0] data_fdb_o;
  logic [DATA_WIDTH-1:0] data_ref_o;
  logic                  tready_i;

  modport master (
    output data_valid_o, data_chn_o, data_fdb_o, data_ref_o,
    input  tready_i
  );

  modport slave (
    input  data_valid_o, data_chn_o, data_fdb_o, data_ref_o,
    output tready_i
  );
endinterface

// File: rtl/pid_chn_scheduler.sv
// Round-robin scheduler that pairs each channel's newest RPM sample with its
// setpoint and issues them one at a time to the shared PID data port.
module pid_chn_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHN    = 4,
  parameter int CHN_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHN-1:0]            rpm_valid_i,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
  input  logic [NUM_CHN-1:0]            chn_en_i,
  input  logic                          ref_valid_i,
  input  logic [CHN_WIDTH-1:0]          ref_chn_i,
  input  logic [DATA_WIDTH-1:0]         ref_data_i,
  input  logic [NUM_CHN-1:0]            ovf_clr_i,
  output logic [NUM_CHN-1:0]            ovf_o,
  pid_chn_scheduler_if.master           pid_if
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [NUM_CHN-1:0]    pend_q, pend_d;
  logic [NUM_CHN-1:0]    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] hold_q [NUM_CHN];
  logic [DATA_WIDTH-1:0] hold_d [NUM_CHN];
  logic [DATA_WIDTH-1:0] ref_q  [NUM_CHN];
  logic [DATA_WIDTH-1:0] ref_d  [NUM_CHN];
  logic [CHN_WIDTH-1:0]  last_q, last_d;
  logic                  valid_q, valid_d;
  logic [CHN_WIDTH-1:0]  chn_q, chn_d;
  logic [DATA_WIDTH-1:0] fdb_q, fdb_d;
  logic [DATA_WIDTH-1:0] refo_q, refo_d;

  logic                  grant_vld;
  logic [CHN_WIDTH-1:0]  grant_idx;
  logic [NUM_CHN-1:0]    grant_oh;
  logic [NUM_CHN-1:0]    capture;
  int                    rr_dist, rr_best;

  // Round-robin arbiter: smallest forward distance from last_q wins, so the
  // channel just served (distance NUM_CHN) has lowest priority.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned and a latch is never inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    rr_dist   = 0;
    rr_best   = NUM_CHN + 1;
    for (int k = 0; k < NUM_CHN; k++) begin
      rr_dist = (k > int'(last_q)) ? k - int'(last_q) : k - int'(last_q) + NUM_CHN;
      if (pend_q[k] && chn_en_i[k] && rr_dist < rr_best) begin
        rr_best   = rr_dist;
        grant_vld = (state_q == IDLE);
        grant_idx = CHN_WIDTH'(k);
      end
    end
    for (int k = 0; k < NUM_CHN; k++) begin
      grant_oh[k] = grant_vld && (grant_idx == CHN_WIDTH'(k));
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant_vld) state_d = SEND;
      SEND: if (valid_q && pid_if.tready_i) state_d = IDLE;
    endcase
  end

  // Output logic: request registers load on grant, valid clears on handshake.
  always_comb begin
    valid_d = valid_q;
    chn_d   = chn_q;
    fdb_d   = fdb_q;
    refo_d  = refo_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (grant_vld) begin
        valid_d = 1'b1;
        chn_d   = grant_idx;
        last_d  = grant_idx;
        for (int k = 0; k < NUM_CHN; k++) begin
          if (grant_oh[k]) begin
            fdb_d  = hold_q[k];
            refo_d = ref_q[k];
          end
        end
      end
      SEND: if (pid_if.tready_i) valid_d = 1'b0;
    endcase
  end

  // Per-channel sample, pending, overrun and setpoint bookkeeping. A capture
  // on the channel being granted re-arms pend without flagging an overrun.
  always_comb begin
    capture = '0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < NUM_CHN; k++) begin
      capture[k] = rpm_valid_i[k] && chn_en_i[k];
      hold_d[k]  = capture[k] ? rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH] : hold_q[k];
      ref_d[k]   = (ref_valid_i && ref_chn_i == CHN_WIDTH'(k)) ? ref_data_i : ref_q[k];

      if (!chn_en_i[k])     pend_d[k] = 1'b0;
      else if (capture[k])  pend_d[k] = 1'b1;
      else if (grant_oh[k]) pend_d[k] = 1'b0;

      if (capture[k] && pend_q[k] && !grant_oh[k]) ovf_d[k] = 1'b1;
      else if (ovf_clr_i[k])                       ovf_d[k] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= '0;
      last_q  <= CHN_WIDTH'(NUM_CHN - 1);
      valid_q <= 1'b0;
      chn_q   <= '0;
      fdb_q   <= '0;
      refo_q  <= '0;
      // NOTE: the small sample/setpoint arrays are reset so a grant issued
      // before any write carries zero instead of an unknown value.
      for (int k = 0; k < NUM_CHN; k++) begin
        hold_q[k] <= '0;
        ref_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      chn_q   <= chn_d;
      fdb_q   <= fdb_d;
      refo_q  <= refo_d;
      for (int k = 0; k < NUM_CHN; k++) begin
        hold_q[k] <= hold_d[k];
        ref_q[k]  <= ref_d[k];
      end
    end
  end

  assign pid_if.data_valid_o = valid_q;
  assign pid_if.data_chn_o   = chn_q;
  assign pid_if.data_fdb_o   = fdb_q;
  assign pid_if.data_ref_o   = refo_q;
  assign ovf_o               = ovf_q;

endmodule

// File: doc/pid_chn_scheduler.md
# pid_chn_scheduler

Sequences the four per-motor RPM feedback streams into the single shared channel-multiplexed PID data port. Each channel's latest speed sample is held as pending, paired with that channel's reference (setpoint), and issued one channel at a time under a valid/ready handshake with round-robin fairness. Reference setpoints are loaded per channel from the UART command path. The block sits between the RPM readers / UART controller and the PID core's `data_*` input.

## Interface
- `DATA_WIDTH`, 16, width of RPM feedback and reference words
- `NUM_CHN`, 4, number of motor channels (2..7)
- `CHN_WIDTH`, 3, channel index width
- `clk` in 1: system clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `rpm_valid_i` in NUM_CHN: per-channel one-cycle sample strobe from RPM readers
- `rpm_data_i` in NUM_CHN*DATA_WIDTH: packed samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `chn_en_i` in NUM_CHN: channel enable mask
- `ref_valid_i` in 1: setpoint write strobe
- `ref_chn_i` in CHN_WIDTH: setpoint target channel
- `ref_data_i` in DATA_WIDTH: setpoint value
- `tready_i` in 1: PID core ready to accept
- `data_valid_o` out 1: request to PID core
- `data_chn_o` out CHN_WIDTH: channel of issued request
- `data_fdb_o` out DATA_WIDTH: feedback (RPM) sample
- `data_ref_o` out DATA_WIDTH: reference for that channel
- `ovf_o` out NUM_CHN: sticky per-channel overrun flags
- `ovf_clr_i` in NUM_CHN: per-channel overrun clear

## Operation
- Per channel k: `pend[k]`, `hold[k]` (DATA_WIDTH), `ref[k]` (DATA_WIDTH).
- Sample capture: `rpm_valid_i[k] && chn_en_i[k]` → `hold[k]` ← sample, `pend[k]` ← 1. Disabled channel: strobe ignored; any `pend[k]` cleared next cycle.
- Overrun: capture while `pend[k]` already 1 and k not granted this cycle → `hold[k]` overwritten (newest wins), `ovf_o[k]` ← 1. `ovf_clr_i[k]` clears; set wins over simultaneous clear.
- Ref write: `ref_valid_i` with `ref_chn_i < NUM_CHN` → `ref[ref_chn_i]` ← `ref_data_i`; index ≥ NUM_CHN ignored. Write takes effect for grants on the following cycle onward.
- FSM states: IDLE, SEND.
  - IDLE: if any `pend & chn_en_i`, pick channel g by round-robin starting at `last+1` mod NUM_CHN; register `data_chn_o`←g, `data_fdb_o`←`hold[g]`, `data_ref_o`←`ref[g]`, `data_valid_o`←1, `pend[g]`←0, `last`←g, go SEND. Otherwise stay.
  - SEND: hold all `data_*` outputs stable. On `data_valid_o && tready_i`: `data_valid_o`←0, go IDLE.
- Same-cycle grant and new capture on channel g: granted output carries old `hold[g]`; `pend[g]` stays 1 with new data; no overrun flag.
- Disabling a channel during SEND does not abort the in-flight request.
- Outputs are pure registers; `data_chn_o/fdb/ref` keep last values after handshake.

## Timing
- Reset: `data_valid_o`=0, `data_chn_o`=0, `data_fdb_o`=0, `data_ref_o`=0, `ovf_o`=0, all `pend`=0, all `ref`=0, `last`=NUM_CHN-1 (channel 0 has first priority), state IDLE. Reset mid-SEND drops the request; `data_valid_o` low the cycle after `rst` sampled.
- Latency: strobe at edge t → `pend` at t+1 → `data_valid_o` high after edge t+2 (idle block).
- Throughput: one transfer per 2 cycles max (SEND accept cycle, then IDLE grant cycle).
- `data_valid_o` never drops without handshake (except reset); `data_*` never change while valid && !tready.
- Round-robin guarantees any pending enabled channel is issued within NUM_CHN grants.

## Test plan
- Single channel: reset, `ref` ch2 ← 0x0100, strobe ch2 with 0x0050, `tready_i`=1 → `data_valid_o` high 2 cycles after strobe with chn=2, fdb=0x0050, ref=0x0100, for exactly 1 cycle.
- Fairness: all four channels strobed same cycle (0x11,0x22,0x33,0x44), `tready_i`=1 → issue order ch0,ch1,ch2,ch3, one every 2 cycles; later strobe ch0+ch3 after last=3 → ch0 then ch3.
- Backpressure: `tready_i`=0 for 10 cycles during SEND → outputs stable all 10 cycles; single transfer when `tready_i` rises.
- Overrun: with `tready_i`=0 holding ch0, strobe ch1 with 0x10 then 0x20 → `ovf_o[1]`=1, ch1 later issued with 0x20 once; `ovf_clr_i[1]` clears; clear+new overrun same cycle → stays 1.
- Enable/ref edges: `chn_en_i[3]`=0 strobe ch3 → nothing issued; ref write with `ref_chn_i`=5 → no ref changes; same-cycle grant+new strobe ch1 → two issues, old then new data.
- Reset mid-SEND: assert `rst` with `data_valid_o`=1 → all outputs 0 next cycle, no pending channels reissued.
